// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode and state encodings shared by the sequential ALU.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// alu_mul_iter : iterative shift-add multiplier, one partial product per cycle.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] sum;

   assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   // The last step's sum is handed out directly so the result lands on the same edge.
   assign done_o    = (cnt_q == CNT_W'(1));
   assign product_o = sum;

   always_comb begin
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start_i) begin
         cnt_d    = CNT_W'(WIDTH);
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (cnt_q != '0) begin
         cnt_d    = cnt_q - CNT_W'(1);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = sum;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : handshaked EX-stage ALU with registered result/flags, iterative MUL.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [2:0]       ALUCtrl_i,
   output logic             valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             Zero_o,
   output logic             Overflow_o
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             zero_q,  zero_d;
   logic             ovf_q,   ovf_d;

   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0] sum, diff, alu_res;
   logic             alu_ovf, lt;

   assign ready_o   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i);
   assign accept    = valid_i & ready_o;
   assign mul_start = accept & (ALUCtrl_i == ALU_MUL);

   assign valid_o    = (state_q == ST_DONE);
   assign data_o     = data_q;
   assign Zero_o     = zero_q;
   assign Overflow_o = ovf_q;

   assign sum  = data1_i + data2_i;
   assign diff = data1_i - data2_i;
   assign lt   = $signed(data1_i) < $signed(data2_i);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ALUCtrl_i)
         ALU_AND: alu_res = data1_i & data2_i;
         ALU_OR:  alu_res = data1_i | data2_i;
         ALU_ADD: begin
            alu_res = sum;
            alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) & (sum[WIDTH-1] != data1_i[WIDTH-1]);
         end
         ALU_XOR: alu_res = data1_i ^ data2_i;
         ALU_SLL: alu_res = data1_i << data2_i[SHW-1:0];
         ALU_SUB: begin
            alu_res = diff;
            alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) & (diff[WIDTH-1] != data1_i[WIDTH-1]);
         end
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
         default: alu_res = '0;
      endcase
   end

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (mul_start),
      .a_i      (data1_i),
      .b_i      (data2_i),
      .done_o   (mul_done),
      .product_o(mul_prod)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if ((state_q == ST_DONE) & out_ready_i & ~valid_i) begin
               state_d = ST_IDLE;
            end
            if (accept) begin
               if (ALUCtrl_i == ALU_MUL) begin
                  state_d = ST_MUL;
               end else begin
                  state_d = ST_DONE;
                  data_d  = alu_res;
                  zero_d  = (alu_res == '0);
                  ovf_d   = alu_ovf;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_DONE;
               data_d  = mul_prod;
               zero_d  = (mul_prod == '0);
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : randomized self-checking bench for alu_seq (WIDTH 32 and 8).
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

   localparam logic [2:0] OP_AND = 3'd0, OP_OR  = 3'd1, OP_ADD = 3'd2, OP_XOR = 3'd3;
   localparam logic [2:0] OP_SLL = 3'd4, OP_MUL = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;

   logic        clk, rst;
   logic        sel;
   logic        req_valid, out_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   int          n_checks, n_fail;

   logic        v32, rdy32, vld32, z32, o32;
   logic [31:0] d32;
   logic        v8, rdy8, vld8, z8, o8;
   logic [7:0]  d8;

   logic        obs_ready, obs_valid, obs_zero, obs_ovf;
   logic [31:0] obs_data;

   assign v32       = req_valid & ~sel;
   assign v8        = req_valid & sel;
   assign obs_ready = sel ? rdy8 : rdy32;
   assign obs_valid = sel ? vld8 : vld32;
   assign obs_zero  = sel ? z8   : z32;
   assign obs_ovf   = sel ? o8   : o32;
   assign obs_data  = sel ? {24'h0, d8} : d32;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(rdy32),
      .data1_i(req_a), .data2_i(req_b), .ALUCtrl_i(req_op),
      .valid_o(vld32), .out_ready_i(out_ready), .data_o(d32),
      .Zero_o(z32), .Overflow_o(o32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(rdy8),
      .data1_i(req_a[7:0]), .data2_i(req_b[7:0]), .ALUCtrl_i(req_op),
      .valid_o(vld8), .out_ready_i(out_ready), .data_o(d8),
      .Zero_o(z8), .Overflow_o(o8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: values treated as integers mod 2^w; overflow means the true
   // signed result falls outside the w-bit two's-complement range.
   function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
      longint unsigned mask, ua, ub, r;
      longint          sa, sb, full, half;
      logic            ovf;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'h0, a} & mask;
      ub   = {32'h0, b} & mask;
      half = longint'(64'd1 << (w - 1));
      sa   = longint'(ua);
      sb   = longint'(ub);
      if (sa >= half) sa = sa - 2 * half;
      if (sb >= half) sb = sb - 2 * half;
      ovf  = 1'b0;
      full = 0;
      r    = 0;
      case (op)
         OP_AND: r = ua & ub;
         OP_OR:  r = ua | ub;
         OP_XOR: r = ua ^ ub;
         OP_ADD: begin r = ua + ub; full = sa + sb; ovf = (full >= half) || (full < -half); end
         OP_SUB: begin r = ua - ub; full = sa - sb; ovf = (full >= half) || (full < -half); end
         OP_SLL: r = ua << (ub % longint'(w));
         OP_MUL: r = ua * ub;
         OP_SLT: r = (sa < sb) ? 64'd1 : 64'd0;
         default: r = 0;
      endcase
      r = r & mask;
      return {ovf, r[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      int          w, tries, lat;
      logic        ready_seen;
      logic [32:0] exp;
      w   = sel ? 8 : 32;
      exp = ref_alu(op, a, b, w);
      req_op = op; req_a = a; req_b = b;
      req_valid = 1'b1; out_ready = 1'b1;
      #1;
      tries = 0;
      while (!obs_ready && tries < 50) begin
         @(posedge clk); #1;
         tries++;
      end
      check("accept_wait", 32'(tries), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; out_ready = 1'b0;
      lat = 0;
      ready_seen = 1'b0;
      while (!obs_valid && lat < 100) begin
         if (obs_ready) ready_seen = 1'b1;
         // a request while busy must be ignored
         if (lat == w / 2) begin
            req_valid = 1'b1; req_op = OP_ADD;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      req_op = op;
      if (op == OP_MUL) check("mul_ready_low", {31'h0, ready_seen}, 32'd0);
      check("latency", 32'(lat), (op == OP_MUL) ? 32'(w) : 32'd0);
      check("data", obs_data, exp[31:0]);
      check("zero", {31'h0, obs_zero}, {31'h0, exp[31:0] == 32'h0});
      check("ovf", {31'h0, obs_ovf}, {31'h0, exp[32]});
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_op = 3'($urandom_range(0, 7));
         req_a = $urandom();
         @(posedge clk); #1;
         check("hold_valid", {31'h0, obs_valid}, 32'd1);
         check("hold_data", obs_data, exp[31:0]);
      end
      req_valid = 1'b0;
   endtask

   task automatic drain();
      req_valid = 1'b0; out_ready = 1'b1;
      #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drain_valid", {31'h0, obs_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
      req_op = OP_AND; req_a = '0; req_b = '0;
      n_checks = 0; n_fail = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_valid", {31'h0, obs_valid}, 32'd0);
      check("rst_data", obs_data, 32'd0);
      check("rst_zero", {31'h0, obs_zero}, 32'd0);
      check("rst_ready", {31'h0, obs_ready}, 32'd1);

      // Reset in the middle of a multiply
      req_op = OP_MUL; req_a = 32'd5; req_b = 32'd7; req_valid = 1'b1;
      #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_valid", {31'h0, obs_valid}, 32'd0);
      check("midrst_data", obs_data, 32'd0);
      check("midrst_ovf", {31'h0, obs_ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_ready", {31'h0, obs_ready}, 32'd1);
      repeat (40) begin
         @(posedge clk); #1;
         if (obs_valid) break;
      end
      check("midrst_no_result", {31'h0, obs_valid}, 32'd0);
      run_op(OP_ADD, 32'd2, 32'd3, 0);

      // Back-to-back single-cycle ops
      run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
      run_op(OP_SUB, 32'd5, 32'd5, 0);
      run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 0);
      run_op(OP_MUL, 32'd12345, 32'd678, 0);
      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(OP_MUL, 32'd0, 32'd1234, 0);
      run_op(OP_AND, 32'hFF, 32'h0F, 5);
      run_op(OP_OR, 32'h1234_0000, 32'h0000_5678, 0);
      drain();

      sel = 1'b1;
      run_op(OP_MUL, 32'd16, 32'd16, 0);
      run_op(OP_SLL, 32'd1, 32'd9, 0);
      run_op(OP_ADD, 32'h7F, 32'h01, 0);
      drain();

      for (int n = 0; n < 80; n++) begin
         logic new_sel;
         new_sel = 1'($urandom_range(0, 1));
         if (new_sel != sel) begin
            drain();
            sel = new_sel;
         end
         run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle combinational ALU of the project CPU. It keeps the existing 3-bit ALUCtrl encoding, adds XOR, SLL and SLT, registers all results, and provides signed-overflow and zero flags. MUL is computed by an iterative shift-add unit instead of a combinational multiplier. It sits in the EX stage of the multi-cycle/stall-capable pipeline; the hazard unit stalls on ready_o/valid_o.

Parameters:
WIDTH, 32, operand/result width in bits; must be at least 2.
CNT_W, $clog2(WIDTH+1), multiply iteration counter width; derived, not overridden.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
valid_i  input  1  operation request valid.
ready_o  output  1  block can accept a request this cycle.
data1_i  input  WIDTH  operand A.
data2_i  input  WIDTH  operand B.
ALUCtrl_i  input  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLL, 101 MUL, 110 SUB, 111 SLT (signed).
valid_o  output  1  result valid.
out_ready_i  input  1  consumer takes result this cycle.
data_o  output  WIDTH  registered result.
Zero_o  output  1  data_o == 0, registered with data_o.
Overflow_o  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst_i low, any time, including mid-multiply): state IDLE, ready_o=1 after release, valid_o=0, data_o=0, Zero_o=0, Overflow_o=0, counter and multiplier regs cleared. The in-flight operation is discarded.
- States: IDLE, MUL, DONE.
- ready_o = (state==IDLE) | (state==DONE & out_ready_i). Accept = valid_i & ready_o. Operands and opcode are sampled only on accept.
- Non-MUL accept: result, Zero and Overflow are registered at that edge; next state DONE. Latency 1 cycle (valid_o high on the cycle after accept).
- MUL accept: load multiplicand=data1_i, multiplier=data2_i, accumulator=0, counter=WIDTH; next state MUL.
- MUL state: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter -= 1. When counter reaches 1, the final step writes data_o=acc (low WIDTH bits, unsigned/two's-complement wrap) and the flags, and the next state is DONE. Latency WIDTH+1 cycles from accept to valid_o.
- DONE: valid_o=1 and data_o/flags held stable until out_ready_i.
  - out_ready_i & !valid_i: go to IDLE, valid_o=0.
  - out_ready_i & valid_i: back-to-back accept; the new op proceeds as from IDLE, so non-MUL ops sustain 1 op/cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow_o = operand signs equal (ADD) or differ (SUB) and the result sign differs from operand A.
  - SLL shifts by data2_i[$clog2(WIDTH)-1:0].
  - SLT yields 1 or 0, zero-extended.
- valid_i while busy (MUL, or DONE without out_ready_i) is ignored; the requester must hold it.
- Opcode changes between requests need no special handling; no X propagation from unused opcodes.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (ALU_AND…ALU_SLT), already shared with ALU_Control.
  - State encoding IDLE/MUL/DONE (2 bits).
- One sub-module, alu_mul_iter: the shift-add datapath with start/done, WIDTH-parametrised, instanced once.
- The combinational ops stay inline.

Test Plan:
- Reset mid-MUL: accept 5*7, assert rst_i low at cycle 10 -> valid_o=0, data_o=0, ready_o=1 after release; a subsequent ADD 2+3 returns 5.
- Single-cycle ops, out_ready_i=1, back-to-back: ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow_o=1. Then SUB 5-5 -> 0, Zero_o=1. Then SLT -1<1 -> 1. Then XOR 0xF0F0^0x0FF0 -> 0xFF00. One result per cycle.
- MUL latency: 12345*678 -> 8369910 exactly 33 cycles after accept. ready_o=0 during MUL; a valid_i pulse mid-MUL is ignored.
- MUL wrap: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, Overflow_o=0. 0*x -> 0, Zero_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles after AND 0xFF&0x0F -> data_o stays 0x0F and valid_o stays 1. A new valid_i is accepted only in the cycle out_ready_i rises.
- WIDTH=8 instance: MUL 16*16 -> 0x00, Zero_o=1, latency 9. SLL 1<<9 uses shamt 1 -> 0x02.
